// File: rtl/conv_pkg.sv
// Shared constants and writer state encoding for the convolution accelerator
// output path.
package conv_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 12;
  localparam logic [ADDR_W-1:0] ADDR_BASE = 12'h000;

  // One extra bit so the column counter can reach DATA_W and flag overflow
  localparam int unsigned COL_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT,
    DONE
  } writer_state_t;

endpackage

// File: rtl/output_row_writer_if.sv
// Pixel stream handshake and output SRAM write port of the row writer.
interface output_row_writer_if
  import conv_pkg::*;
#(
  parameter int unsigned DW = conv_pkg::DATA_W,
  parameter int unsigned AW = conv_pkg::ADDR_W
);

  logic          pix_valid;
  logic          pix_ready;
  logic          pix_data;
  logic          pix_last;
  logic          pix_last_row;
  logic [AW-1:0] dut_sram_write_address;
  logic [DW-1:0] dut_sram_write_data;
  logic          dut_sram_write_enable;

  modport master (
    output pix_valid, pix_data, pix_last, pix_last_row,
    input  pix_ready, dut_sram_write_address, dut_sram_write_data,
           dut_sram_write_enable
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, pix_last_row,
    output pix_ready, dut_sram_write_address, dut_sram_write_data,
           dut_sram_write_enable
  );

endinterface

// File: rtl/row_packer.sv
// Packs incoming result bits MSB-first into one DATA_W word; pixels past
// DATA_W are dropped and raise a sticky overflow flag.
module row_packer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic              overflow
);

  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  logic [COL_W-1:0]  col;
  logic [DATA_W-1:0] col_mask;
  logic              col_full;

  assign col_full = (col >= COL_W'(DATA_W));
  assign col_mask = MSB_MASK >> col;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      word     <= '0;
      col      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      word <= '0;
      col  <= '0;
    end else if (shift_en) begin
      if (col_full) begin
        overflow <= 1'b1;
      end else begin
        if (bit_in) word <= word | col_mask;
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/output_row_writer.sv
// Write-side engine: collects 1-bit results per output row, commits each
// packed row to the output SRAM and signals end of frame.
module output_row_writer #(
  parameter logic [conv_pkg::ADDR_W-1:0] ADDR_BASE = conv_pkg::ADDR_BASE
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      frame_start,
  input  logic                      addr_restart,
  output_row_writer_if.slave        pif,
  output logic                      writer_busy,
  output logic                      writer_done,
  output logic                      overflow_err,
  output logic [7:0]                rows_written
);

  import conv_pkg::*;

  writer_state_t     state, state_next;
  logic              accept;
  logic              last_row_q;
  logic              pack_clear;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_d, busy_d, done_d, we_d;

  assign accept     = (state == COLLECT) && pif.pix_valid;
  assign pack_clear = (state == COMMIT) || ((state == IDLE) && frame_start);

  row_packer u_row_packer (
    .clk      (clk),
    .reset_b  (reset_b),
    .clear    (pack_clear),
    .shift_en (accept),
    .bit_in   (pif.pix_data),
    .word     (pif.dut_sram_write_data),
    .overflow (overflow_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (frame_start) state_next = COLLECT;
      COLLECT: if (accept && pif.pix_last) state_next = COMMIT;
      COMMIT:  state_next = last_row_q ? DONE : COLLECT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one
  // is valid for exactly the cycle the FSM spends in the matching state.
  always_comb begin
    ready_d = (state_next == COLLECT);
    busy_d  = (state_next == COLLECT) || (state_next == COMMIT);
    done_d  = (state_next == DONE);
    we_d    = (state_next == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      pif.pix_ready             <= 1'b0;
      writer_busy               <= 1'b0;
      writer_done               <= 1'b0;
      pif.dut_sram_write_enable <= 1'b0;
    end else begin
      pif.pix_ready             <= ready_d;
      writer_busy               <= busy_d;
      writer_done               <= done_d;
      pif.dut_sram_write_enable <= we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      addr_q       <= ADDR_BASE;
      rows_written <= '0;
      last_row_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (addr_restart) addr_q <= ADDR_BASE;
          if (frame_start)  rows_written <= '0;
        end
        COLLECT: begin
          if (accept && pif.pix_last) last_row_q <= pif.pix_last_row;
        end
        COMMIT: begin
          addr_q <= addr_q + ADDR_W'(1);
          if (rows_written != '1) rows_written <= rows_written + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign pif.dut_sram_write_address = addr_q;

endmodule

// File: tb/tb_output_row_writer.sv
// Directed bench for output_row_writer: two instances (default base and
// base 12'hFFF) driven with identical stimulus.
module tb_output_row_writer;

  logic clk = 1'b0;
  logic rb, fs, ar, pv, pd, pl, plr;

  logic       busy, done, ovf;
  logic [7:0] rows;
  logic       busy_hi, done_hi, ovf_hi;
  logic [7:0] rows_hi;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prev_we = 1'b0;

  logic [11:0] q_addr[$];
  logic [15:0] q_data[$];
  logic [11:0] hi_addr[$];

  always #5 clk = ~clk;

  output_row_writer_if rif ();
  output_row_writer_if rif_hi ();

  assign rif.pix_valid       = pv;
  assign rif.pix_data        = pd;
  assign rif.pix_last        = pl;
  assign rif.pix_last_row    = plr;
  assign rif_hi.pix_valid    = pv;
  assign rif_hi.pix_data     = pd;
  assign rif_hi.pix_last     = pl;
  assign rif_hi.pix_last_row = plr;

  output_row_writer dut (
    .clk          (clk),
    .reset_b      (rb),
    .frame_start  (fs),
    .addr_restart (ar),
    .pif          (rif.slave),
    .writer_busy  (busy),
    .writer_done  (done),
    .overflow_err (ovf),
    .rows_written (rows)
  );

  output_row_writer #(.ADDR_BASE(12'hFFF)) dut_hi (
    .clk          (clk),
    .reset_b      (rb),
    .frame_start  (fs),
    .addr_restart (ar),
    .pif          (rif_hi.slave),
    .writer_busy  (busy_hi),
    .writer_done  (done_hi),
    .overflow_err (ovf_hi),
    .rows_written (rows_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rif.dut_sram_write_enable) begin
      q_addr.push_back(rif.dut_sram_write_address);
      q_data.push_back(rif.dut_sram_write_data);
      check("ready_in_commit", {31'd0, rif.pix_ready}, 32'd0);
    end
    if (rif_hi.dut_sram_write_enable) hi_addr.push_back(rif_hi.dut_sram_write_address);
    if (prev_we && busy) check("ready_after_commit", {31'd0, rif.pix_ready}, 32'd1);
    if (done) done_cnt++;
    prev_we = rif.dut_sram_write_enable;
  end

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    hi_addr.delete();
    done_cnt = 0;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_addr"},  {20'd0, rif.dut_sram_write_address}, 32'h000);
    check({tag, "_data"},  {16'd0, rif.dut_sram_write_data}, 32'h0);
    check({tag, "_we"},    {31'd0, rif.dut_sram_write_enable}, 32'd0);
    check({tag, "_ready"}, {31'd0, rif.pix_ready}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_ovf"},   {31'd0, ovf}, 32'd0);
    check({tag, "_rows"},  {24'd0, rows}, 32'd0);
  endtask

  task automatic do_reset();
    rb = 1'b0; fs = 1'b0; ar = 1'b0; pv = 1'b0; pd = 1'b0; pl = 1'b0; plr = 1'b0;
    repeat (2) @(negedge clk);
    rb = 1'b1;
  endtask

  task automatic pulse_start(input logic restart);
    fs = 1'b1;
    ar = restart;
    @(negedge clk);
    fs = 1'b0;
    ar = 1'b0;
    check("start_busy",  {31'd0, busy}, 32'd1);
    check("start_ready", {31'd0, rif.pix_ready}, 32'd1);
  endtask

  // Pixel i of the row is pat[31-i]; returns at the negedge after the
  // final pixel was accepted, with valid already dropped.
  task automatic send_pixels(input logic [31:0] pat, input int n,
                             input logic is_last, input logic last_row);
    logic [31:0] p;
    p = pat;
    for (int i = 0; i < n; i++) begin
      int wait_n;
      wait_n = 0;
      while (!rif.pix_ready && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      if (wait_n >= 20) check("ready_timeout", 32'd0, 32'd1);
      pv  = 1'b1;
      pd  = p[31-i];
      pl  = is_last && (i == n-1);
      plr = last_row;
      @(negedge clk);
    end
    pv = 1'b0; pd = 1'b0; pl = 1'b0; plr = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check_rst("rst");
    check("rst_hi_addr", {20'd0, rif_hi.dut_sram_write_address}, 32'hFFF);

    // Single four-pixel row, exact commit / done timing
    clear_log();
    pulse_start(1'b0);
    send_pixels(32'hB000_0000, 4, 1'b1, 1'b1);
    check("t1_we",    {31'd0, rif.dut_sram_write_enable}, 32'd1);
    check("t1_addr",  {20'd0, rif.dut_sram_write_address}, 32'h000);
    check("t1_data",  {16'd0, rif.dut_sram_write_data}, 32'hB000);
    @(negedge clk);
    check("t1_done",  {31'd0, done}, 32'd1);
    check("t1_busy",  {31'd0, busy}, 32'd0);
    check("t1_we_off", {31'd0, rif.dut_sram_write_enable}, 32'd0);
    check("t1_rows",  {24'd0, rows}, 32'd1);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_nwr",   q_addr.size(), 32'd1);
    check("t1_ndone", done_cnt, 32'd1);

    // Three rows of 14 ones, restart address together with frame_start
    clear_log();
    pulse_start(1'b1);
    for (int r = 0; r < 3; r++) send_pixels(32'hFFFC_0000, 14, 1'b1, r == 2);
    wait_done();
    check("t2_nwr", q_addr.size(), 32'd3);
    for (int r = 0; r < 3 && r < q_addr.size(); r++) begin
      check("t2_addr", {20'd0, q_addr[r]}, r);
      check("t2_data", {16'd0, q_data[r]}, 32'hFFFC);
    end
    check("t2_ndone", done_cnt, 32'd1);
    check("t2_rows",  {24'd0, rows}, 32'd3);
    check("t2_ovf",   {31'd0, ovf}, 32'd0);

    // 18-pixel row overflows; flag survives into the next frame
    clear_log();
    pulse_start(1'b0);
    send_pixels(32'hFFFF_C000, 18, 1'b1, 1'b1);
    wait_done();
    check("t3_nwr", q_addr.size(), 32'd1);
    if (q_addr.size() > 0) begin
      check("t3_addr", {20'd0, q_addr[0]}, 32'h003);
      check("t3_data", {16'd0, q_data[0]}, 32'hFFFF);
    end
    check("t3_ovf", {31'd0, ovf}, 32'd1);
    clear_log();
    pulse_start(1'b0);
    send_pixels(32'h8000_0000, 1, 1'b1, 1'b1);
    wait_done();
    check("t3b_nwr", q_addr.size(), 32'd1);
    if (q_addr.size() > 0) begin
      check("t3b_addr", {20'd0, q_addr[0]}, 32'h004);
      check("t3b_data", {16'd0, q_data[0]}, 32'h8000);
    end
    check("t3b_ovf", {31'd0, ovf}, 32'd1);

    // Reset clears overflow; base 12'hFFF wraps to 0
    do_reset();
    check("t4_ovf_rst", {31'd0, ovf}, 32'd0);
    clear_log();
    pulse_start(1'b0);
    send_pixels(32'hC000_0000, 3, 1'b1, 1'b0);
    send_pixels(32'h4000_0000, 2, 1'b1, 1'b1);
    wait_done();
    check("t4_nwr", q_addr.size(), 32'd2);
    check("t4_hi_nwr", hi_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check("t4_addr0", {20'd0, q_addr[0]}, 32'h000);
      check("t4_addr1", {20'd0, q_addr[1]}, 32'h001);
      check("t4_data0", {16'd0, q_data[0]}, 32'hC000);
      check("t4_data1", {16'd0, q_data[1]}, 32'h4000);
    end
    if (hi_addr.size() == 2) begin
      check("t4_hi_addr0", {20'd0, hi_addr[0]}, 32'hFFF);
      check("t4_hi_addr1", {20'd0, hi_addr[1]}, 32'h000);
    end
    check("t4_rows", {24'd0, rows}, 32'd2);

    // Reset mid-row: partial row discarded, no write strobe
    clear_log();
    pulse_start(1'b0);
    send_pixels(32'hF800_0000, 5, 1'b0, 1'b0);
    rb = 1'b0;
    @(negedge clk);
    check_rst("t5_rst");
    check("t5_nwr", q_addr.size(), 32'd0);
    rb = 1'b1;
    pulse_start(1'b0);
    send_pixels(32'h8000_0000, 1, 1'b1, 1'b1);
    wait_done();
    check("t5_nwr2", q_addr.size(), 32'd1);
    if (q_addr.size() > 0) begin
      check("t5_addr", {20'd0, q_addr[0]}, 32'h000);
      check("t5_data", {16'd0, q_data[0]}, 32'h8000);
    end

    // Ignored inputs, back-to-back frames, addr_restart in IDLE
    clear_log();
    pv = 1'b1; pd = 1'b1; pl = 1'b1; plr = 1'b1;
    repeat (3) @(negedge clk);
    pv = 1'b0; pd = 1'b0; pl = 1'b0; plr = 1'b0;
    check("t6_idle_nwr",   q_addr.size(), 32'd0);
    check("t6_idle_ready", {31'd0, rif.pix_ready}, 32'd0);
    check("t6_idle_busy",  {31'd0, busy}, 32'd0);
    pulse_start(1'b0);
    send_pixels(32'h8000_0000, 2, 1'b0, 1'b1);
    fs = 1'b1; ar = 1'b1;
    @(negedge clk);
    fs = 1'b0; ar = 1'b0;
    check("t6_mid_busy",  {31'd0, busy}, 32'd1);
    check("t6_mid_ready", {31'd0, rif.pix_ready}, 32'd1);
    send_pixels(32'h4000_0000, 2, 1'b1, 1'b1);
    wait_done();
    pulse_start(1'b0);
    send_pixels(32'h4000_0000, 2, 1'b1, 1'b1);
    wait_done();
    check("t6_nwr", q_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check("t6_addr0", {20'd0, q_addr[0]}, 32'h001);
      check("t6_data0", {16'd0, q_data[0]}, 32'h9000);
      check("t6_addr1", {20'd0, q_addr[1]}, 32'h002);
      check("t6_data1", {16'd0, q_data[1]}, 32'h4000);
    end
    check("t6_ndone", done_cnt, 32'd2);
    clear_log();
    ar = 1'b1;
    @(negedge clk);
    ar = 1'b0;
    pulse_start(1'b0);
    send_pixels(32'h8000_0000, 1, 1'b1, 1'b1);
    wait_done();
    check("t6_rst_nwr", q_addr.size(), 32'd1);
    if (q_addr.size() > 0) begin
      check("t6_rst_addr", {20'd0, q_addr[0]}, 32'h000);
      check("t6_rst_data", {16'd0, q_data[0]}, 32'h8000);
    end
    check("t6_rows", {24'd0, rows}, 32'd1);
    check("t6_ovf",  {31'd0, ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
